mul_iter: RTL and testbench

- Multi-cycle 32x32 -> 64 multiplier for the EX stage, serving MULT and MULTU.
- It is the responder end of the same start/annul/ready handshake the ALU already uses to drive the divider. The ALU holds start high while ready is low and stalls the pipeline until ready.
- It replaces the single-cycle combinational product to relieve the EX critical path.

---
 rtl/mul_pkg.sv | 31 +++
 rtl/mul_iter.sv | 156 +++++++++++++++
 tb/tb_mul_iter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state type and sizing helpers for the iterative multiplier.
// Define MUL_RADIX4_EN to retire two multiplier bits per BUSY cycle.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } mul_state_t;

    localparam int MUL_WIDTH = 32;

    // Number of BUSY cycles for a given operand width
    function automatic int mul_iter_count(input int width);
`ifdef MUL_RADIX4_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

    // Width of the BUSY iteration counter
    function automatic int mul_cnt_width(input int iters);
        return (iters <= 2) ? 1 : $clog2(iters);
    endfunction

    localparam int MUL_ITER  = mul_iter_count(MUL_WIDTH);
    localparam int MUL_CNT_W = mul_cnt_width(MUL_ITER);

endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier for MULT/MULTU in the EX stage.
// Optional: MUL_RADIX4_EN retires two multiplier bits per BUSY cycle.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               signed_mul_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int ITER = mul_iter_count(WIDTH);
    localparam int CW   = mul_cnt_width(ITER);
`ifdef MUL_RADIX4_EN
    localparam int ADD_W = WIDTH + 2;
`else
    localparam int ADD_W = WIDTH + 1;
`endif
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mul_state_t         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mq_step;
    logic               sign_a;
    logic               sign_b;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               zero_op;
    logic [ADD_W-1:0]   addend;
    logic [ADD_W-1:0]   hi_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef MUL_RADIX4_EN
    logic [WIDTH+1:0]   m3;
    logic [WIDTH+1:0]   m3_in;
`endif

    // Operand conditioning: sign flags and magnitudes (0x80..0 stays 0x80..0)
    always_comb begin
        a_neg   = signed_mul_i & a_i[WIDTH-1];
        b_neg   = signed_mul_i & b_i[WIDTH-1];
        a_mag   = a_neg ? (-a_i) : a_i;
        b_mag   = b_neg ? (-b_i) : b_i;
        zero_op = (a_i == '0) || (b_i == '0);
`ifdef MUL_RADIX4_EN
        m3_in   = {2'b00, a_mag} + {1'b0, a_mag, 1'b0};
`endif
    end

    // One shift-add step: add to the upper half, then shift {carry, acc} right
    always_comb begin
        addend   = '0;
        hi_sum   = '0;
        acc_step = acc;
        mq_step  = mq;
`ifdef MUL_RADIX4_EN
        unique case (mq[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, mcand};
            2'd2:    addend = {1'b0, mcand, 1'b0};
            default: addend = m3;
        endcase
        hi_sum   = ADD_W'(acc[2*WIDTH:WIDTH]) + addend;
        acc_step = {1'b0, hi_sum, acc[WIDTH-1:2]};
        mq_step  = {2'b00, mq[WIDTH-1:2]};
`else
        addend   = mq[0] ? {1'b0, mcand} : '0;
        hi_sum   = ADD_W'(acc[2*WIDTH:WIDTH]) + addend;
        acc_step = {1'b0, hi_sum, acc[WIDTH-1:1]};
        mq_step  = {1'b0, mq[WIDTH-1:1]};
`endif
    end

    // Final sign fix-up of the unsigned magnitude product
    always_comb begin
        prod = (sign_a ^ sign_b) ? (-acc[2*WIDTH-1:0])
                                 : acc[2*WIDTH-1:0];
    end

    // Control FSM with registered outputs; annul and reset abort silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef MUL_RADIX4_EN
            m3       <= '0;
`endif
        end else if (annul_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        mcand  <= a_mag;
                        mq     <= b_mag;
`ifdef MUL_RADIX4_EN
                        m3     <= m3_in;
`endif
                        acc    <= '0;
                        cnt    <= '0;
                        if (zero_op) begin
                            result_o <= '0;
                            ready_o  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    mq  <= mq_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_o <= prod;
                    ready_o  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: scoreboard bench for mul_iter against an arithmetic model.
// Honours MUL_RADIX4_EN for the expected latency.
module tb_mul_iter;

    localparam int W = 32;
`ifdef MUL_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             t0;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_mul;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;

    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    exp_t           sbq[$];
    logic [2*W-1:0] last_prod;
    bit             have_last = 0;

    mul_iter #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .signed_mul_i(signed_mul),
        .a_i         (a),
        .b_i         (b),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_mul(input logic sm,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint sx;
        longint sy;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic chk64(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk64("result", result, e.prod);
                chk_int("latency", cyc - e.t0 + 1, e.lat);
            end
        end
    end

    function automatic logic [W-1:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at a negedge and hold start until ready, like the ALU.
    // b2b: called in the DONE cycle of the previous op.
    task automatic issue(input logic sm, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit b2b);
        exp_t e;
        bit   seen;
        signed_mul = sm;
        a          = x;
        b          = y;
        start      = 1'b1;
        e.prod     = ref_mul(sm, x, y);
        e.lat      = (x == '0 || y == '0) ? 1 : LAT;
        e.t0       = cyc + (b2b ? 2 : 1);
        sbq.push_back(e);
        repeat (b2b ? 2 : 1) @(negedge clk);
        a    = $urandom;
        b    = $urandom;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (ready === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready expected ready within 60 cycles");
            sbq.delete();
            start = 1'b0;
            rst   = 1'b1;
            repeat (2) @(negedge clk);
            rst       = 1'b0;
            last_prod = '0;
            have_last = 1;
        end else begin
            last_prod = e.prod;
            have_last = 1;
        end
    endtask

    // Idle one cycle and confirm the previous result is still held
    task automatic idle_hold();
        start = 1'b0;
        @(negedge clk);
        if (have_last) chk64("result_hold", result, last_prod);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_mul = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(negedge clk);
        chk_int("reset_ready", int'(ready), 0);
        chk64("reset_result", result, '0);
        rst       = 1'b0;
        last_prod = '0;
        have_last = 1;

        idle_hold();
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle_hold();
        issue(1'b1, 32'hFFFF_FFFD, 32'd5, 0);
        issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1);
        idle_hold();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1);
        idle_hold();
        issue(1'b0, 32'h0, 32'h1234, 0);
        issue(1'b1, 32'h7, 32'h0, 1);
        issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1);

        // Annul in the middle of an operation, then restart
        idle_hold();
        signed_mul = 1'b0;
        a          = 32'd100;
        b          = 32'd200;
        start      = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        chk_int("annul_no_ready", int'(ready), 0);
        @(negedge clk);
        issue(1'b0, 32'd3, 32'd4, 0);

        // Reset in the middle of an operation
        idle_hold();
        signed_mul = 1'b1;
        a          = 32'h0001_2345;
        b          = 32'h0000_0777;
        start      = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_int("midop_reset_ready", int'(ready), 0);
        chk64("midop_reset_result", result, '0);
        rst       = 1'b0;
        start     = 1'b0;
        last_prod = '0;
        have_last = 1;

        // Randomized operations with random back-to-back spacing
        idle_hold();
        for (int k = 0; k < 40; k++) begin
            logic sm;
            bit   b2b;
            sm  = 1'($urandom_range(0, 1));
            b2b = (k != 0) && ($urandom_range(0, 2) == 0);
            if (!b2b) idle_hold();
            issue(sm, pick_operand(), pick_operand(), b2b);
        end

        start = 1'b0;
        repeat (5) @(negedge clk);
        chk_int("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
